// File: rtl/i2c_xact_master_pkg.sv
// Shared types and constants for the byte-level I2C transaction master.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK,
    S_RSTART, S_RD, S_RD_ACK, S_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Quarter phases inside one bit time.
  localparam logic [1:0] Q_DRIVE = 2'd0;  // SCL low, SDA may change
  localparam logic [1:0] Q_RISE  = 2'd1;  // SCL released
  localparam logic [1:0] Q_HIGH  = 2'd2;  // SCL high, SDA sampled at its end
  localparam logic [1:0] Q_FALL  = 2'd3;  // SCL pulled low

endpackage

// File: rtl/i2c_xact_master_if.sv
// Request/response and pad signals between the expander controller, the
// transaction master and the open-drain pad buffers.
interface i2c_xact_master_if;
  logic       start;
  logic       done;
  logic       nack;
  logic [6:0] addr;
  logic [1:0] num_wr_bytes;
  logic [1:0] num_rd_bytes;
  logic [7:0] wr_data0, wr_data1, wr_data2;
  logic [7:0] rd_data0, rd_data1;
  logic       scl_i, scl_oe;
  logic       sda_i, sda_oe;

  modport master (
    input  start, addr, num_wr_bytes, num_rd_bytes, wr_data0, wr_data1, wr_data2,
           scl_i, sda_i,
    output done, nack, rd_data0, rd_data1, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, num_wr_bytes, num_rd_bytes, wr_data0, wr_data1, wr_data2,
           scl_i, sda_i,
    input  done, nack, rd_data0, rd_data1, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_xact_master_tick_gen.sv
// Quarter-bit strobe: DIV-cycle down-counter, held at reload while cleared
// and frozen while a slave stretches SCL.
module i2c_tick_gen #(
  parameter int DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count down one quarter, reload on expiry; hold during stretch.
  always_ff @(posedge clk) begin
    if (reset || clr_i)      cnt_q <= RELOAD;
    else if (!hold_i)        cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
  end

  assign tick_o = (cnt_q == '0) && !hold_i && !clr_i;
endmodule

// File: rtl/i2c_xact_master.sv
// One complete I2C transaction per request: START, address, up to three
// writes, optional repeated START, up to two reads, STOP.
module i2c_xact_master
  import i2c_pkg::*;
#(
  parameter int DIV = 250
) (
  input logic               clk,
  input logic               reset,
  i2c_xact_master_if.master bus
);
  i2c_state_e       state_q, state_d, after_wr;
  logic [1:0]       qtr_q, qtr_d, byte_q, byte_d, nwr_q, nwr_d, nrd_q, nrd_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0][7:0]  wr_q, wr_d;
  logic             rw_q, rw_d, done_q, done_d, nack_q, nack_d;
  logic             scl_oe, sda_oe, stretch, tick, sample, bit_end, rd_last;

  // A slave holding SCL low after we release it pauses the bit clock.
  assign stretch = !scl_oe && !bus.scl_i;
  assign sample  = tick && (qtr_q == Q_HIGH);
  assign bit_end = tick && (qtr_q == Q_FALL);
  assign rd_last = (byte_q + 2'd1) == nrd_q;

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk), .reset(reset), .clr_i(state_q == S_IDLE), .hold_i(stretch), .tick_o(tick)
  );

  // State and datapath registers; reset releases the bus at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; qtr_q <= '0; bit_q <= '0; byte_q <= '0; sh_q <= '0;
      addr_q <= '0; nwr_q <= '0; nrd_q <= '0; wr_q <= '0; rw_q <= I2C_RW_WRITE;
      rd0_q <= '0; rd1_q <= '0; done_q <= 1'b1; nack_q <= 1'b0;
    end else begin
      state_q <= state_d; qtr_q <= qtr_d; bit_q <= bit_d; byte_q <= byte_d; sh_q <= sh_d;
      addr_q <= addr_d; nwr_q <= nwr_d; nrd_q <= nrd_d; wr_q <= wr_d; rw_q <= rw_d;
      rd0_q <= rd0_d; rd1_q <= rd1_d; done_q <= done_d; nack_q <= nack_d;
    end
  end

  // Next-state: phase sequencing, shifting, ACK handling.
  always_comb begin
    state_d = state_q; qtr_d = qtr_q; bit_d = bit_q; byte_d = byte_q; sh_d = sh_q;
    addr_d = addr_q; nwr_d = nwr_q; nrd_d = nrd_q; wr_d = wr_q; rw_d = rw_q;
    rd0_d = rd0_q; rd1_d = rd1_q; done_d = done_q; nack_d = nack_q;
    // Where a write-phase ACK leads when the slave accepted it.
    if (byte_q < nwr_q)      after_wr = S_WR;
    else if (nrd_q != 2'd0)  after_wr = S_RSTART;
    else                     after_wr = S_STOP;
    if (tick) qtr_d = qtr_q + 2'd1;
    case (state_q)
      S_IDLE: begin
        qtr_d = Q_DRIVE;
        if (bus.start) begin
          addr_d = bus.addr;
          nwr_d  = bus.num_wr_bytes;
          nrd_d  = (bus.num_rd_bytes == 2'd3) ? 2'd2 : bus.num_rd_bytes;
          wr_d   = {8'h00, bus.wr_data2, bus.wr_data1, bus.wr_data0};
          rw_d   = (bus.num_wr_bytes != 2'd0 || bus.num_rd_bytes == 2'd0) ? I2C_RW_WRITE
                                                                          : I2C_RW_READ;
          byte_d = 2'd0; done_d = 1'b0; nack_d = 1'b0; state_d = S_START;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_ADDR; sh_d = {addr_q, rw_q}; bit_d = 3'd0;
      end
      S_RSTART: if (bit_end) begin
        state_d = S_ADDR; rw_d = I2C_RW_READ; sh_d = {addr_q, I2C_RW_READ}; bit_d = 3'd0;
      end
      S_ADDR, S_WR: if (bit_end) begin
        if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
        else begin
          bit_d = bit_q + 3'd1; sh_d = {sh_q[6:0], 1'b0};
        end
      end
      S_ADDR_ACK, S_WR_ACK: begin
        // nack was cleared at start, so it is set here only by this bit.
        if (sample && bus.sda_i) nack_d = 1'b1;
        if (bit_end) begin
          bit_d = 3'd0;
          if (nack_q) state_d = S_STOP;
          else if (state_q == S_ADDR_ACK && rw_q == I2C_RW_READ) begin
            state_d = S_RD; byte_d = 2'd0;
          end else begin
            state_d = after_wr;
            if (after_wr == S_WR) begin
              sh_d = wr_q[byte_q]; byte_d = byte_q + 2'd1;
            end
          end
        end
      end
      S_RD: begin
        if (sample) sh_d = {sh_q[6:0], bus.sda_i};
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_RD_ACK;
            if (byte_q == 2'd0) rd0_d = sh_q;
            else                rd1_d = sh_q;
          end else bit_d = bit_q + 3'd1;
        end
      end
      S_RD_ACK: if (bit_end) begin
        bit_d = 3'd0; byte_d = byte_q + 2'd1;
        state_d = rd_last ? S_STOP : S_RD;
      end
      S_STOP: if (bit_end) begin
        state_d = S_IDLE; done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pad drive from state and quarter: 1 pulls the line low.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_IDLE: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
      S_START, S_RSTART: begin
        scl_oe = (qtr_q == Q_DRIVE) || (qtr_q == Q_FALL);
        sda_oe = (qtr_q == Q_HIGH)  || (qtr_q == Q_FALL);
      end
      S_STOP: begin
        scl_oe = (qtr_q == Q_DRIVE);
        sda_oe = (qtr_q != Q_FALL);
      end
      S_ADDR, S_WR: begin
        scl_oe = (qtr_q == Q_DRIVE) || (qtr_q == Q_FALL);
        sda_oe = !sh_q[7];
      end
      S_RD_ACK: begin
        scl_oe = (qtr_q == Q_DRIVE) || (qtr_q == Q_FALL);
        sda_oe = !rd_last;
      end
      default: scl_oe = (qtr_q == Q_DRIVE) || (qtr_q == Q_FALL);
    endcase
  end

  assign bus.scl_oe   = scl_oe;
  assign bus.sda_oe   = sda_oe;
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.rd_data0 = rd0_q;
  assign bus.rd_data1 = rd1_q;
endmodule

// File: tb/tb_i2c_xact_master.sv
// Bench: open-drain bus with a slave model at 0x20, bus-token scoreboard.
module tb_i2c_xact_master;
  localparam int DIV   = 4;
  localparam int TOK_S = 'h1000;
  localparam int TOK_P = 'h2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_xact_master_if bus_if();
  i2c_xact_master #(.DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  logic slv_scl_low, slv_sda_low, scl, sda;
  assign scl = ~(bus_if.scl_oe | slv_scl_low);
  assign sda = ~(bus_if.sda_oe | slv_sda_low);
  assign bus_if.scl_i = scl;
  assign bus_if.sda_i = sda;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int tk(input logic nak, input logic [7:0] b);
    return int'({nak, b});
  endfunction

  // ---------------- slave model / bus monitor (acts on negedge) ----------
  logic       pscl, psda, match, mrw, mack, hold_sda;
  logic [7:0] msh;
  logic [7:0] rd_src [0:1] = '{8'h5A, 8'hC3};
  int         mbit, mph, wr_idx, rd_idx, hold_cnt;
  bit         stretch_arm = 0, mon_clr = 0, hold_seen, sda_moved;

  initial begin
    slv_scl_low = 0; slv_sda_low = 0; pscl = 1; psda = 1; mbit = 0; mph = 0;
    wr_idx = 0; rd_idx = 0; hold_cnt = 0; hold_seen = 0; sda_moved = 0;
    msh = 0; match = 0; mrw = 0; mack = 0; hold_sda = 1;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        mph = 0; mbit = 0; slv_scl_low = 0; slv_sda_low = 0; pscl = scl; psda = sda;
      end else begin
        if (slv_scl_low && !bus_if.scl_oe) begin
          if (hold_cnt == 101) hold_sda = sda;
          else if (sda !== hold_sda) sda_moved = 1;
          hold_cnt--;
          if (hold_cnt == 0) slv_scl_low = 0;
        end
        if (pscl && scl && psda && !sda) begin
          got_q.push_back(TOK_S); mph = 1; mbit = 0; slv_sda_low = 0;
        end else if (pscl && scl && !psda && sda) begin
          got_q.push_back(TOK_P); mph = 0; mbit = 0; slv_sda_low = 0;
        end else if (!pscl && scl) begin
          if (mbit < 8) begin msh = {msh[6:0], sda}; mbit++; end
          else begin mack = sda; got_q.push_back(tk(mack, msh)); mbit = 9; end
        end else if (pscl && !scl) begin
          if (mbit == 8) begin
            if (mph == 1) begin
              match = (msh[7:1] == 7'h20); mrw = msh[0]; slv_sda_low = match;
            end else slv_sda_low = (mph == 2);
          end else if (mbit == 9) begin
            mbit = 0; slv_sda_low = 0;
            if (mph == 1) begin
              if (!match) mph = 0;
              else if (mrw) begin mph = 3; rd_idx = 0; slv_sda_low = ~rd_src[0][7]; end
              else begin mph = 2; wr_idx = 0; end
            end else if (mph == 2) wr_idx++;
            else if (mph == 3) begin
              if (mack) mph = 0;
              else begin rd_idx++; slv_sda_low = ~rd_src[rd_idx][7]; end
            end
          end else if (mph == 3 && mbit >= 1) slv_sda_low = ~rd_src[rd_idx][7 - mbit];
          // Stretch during bit 3 of the first write byte.
          if (mph == 2 && wr_idx == 0 && mbit == 4 && stretch_arm && !hold_seen) begin
            slv_scl_low = 1; hold_cnt = 101; hold_seen = 1; sda_moved = 0;
          end
        end
        pscl = scl; psda = sda;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input string tag, input logic [6:0] a, input logic [1:0] nw,
                     input logic [1:0] nr, input logic [7:0] d0, d1, d2,
                     input int exp_cyc, input bit poke);
    int cyc;
    @(negedge clk);
    bus_if.addr = a; bus_if.num_wr_bytes = nw; bus_if.num_rd_bytes = nr;
    bus_if.wr_data0 = d0; bus_if.wr_data1 = d1; bus_if.wr_data2 = d2; bus_if.start = 1;
    @(posedge clk); #1;
    bus_if.start = 0;
    chk({tag, "_done_fall"}, bus_if.done, 1'b0);
    // Inputs change after the latch edge and must not matter.
    bus_if.addr = ~a; bus_if.num_wr_bytes = ~nw; bus_if.num_rd_bytes = ~nr;
    bus_if.wr_data0 = ~d0; bus_if.wr_data1 = ~d1; bus_if.wr_data2 = ~d2;
    cyc = 0;
    while (!bus_if.done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      bus_if.start = (poke && cyc == 20);
    end
    bus_if.start = 0;
    chk({tag, "_busy"}, cyc, exp_cyc);
  endtask

  task automatic cmp_tokens(input string tag);
    int e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      chk({tag, "_tok"}, g, e);
    end
    chk({tag, "_extra"}, got_q.size(), 0);
  endtask

  initial begin
    int k;
    bus_if.start = 0; bus_if.addr = 0; bus_if.num_wr_bytes = 0; bus_if.num_rd_bytes = 0;
    bus_if.wr_data0 = 0; bus_if.wr_data1 = 0; bus_if.wr_data2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", bus_if.done, 1'b1);
    chk("rst_nack", bus_if.nack, 1'b0);
    chk("rst_rd0", bus_if.rd_data0, 8'h00);
    chk("rst_rd1", bus_if.rd_data1, 8'h00);
    chk("rst_scl", bus_if.scl_oe, 1'b0);
    chk("rst_sda", bus_if.sda_oe, 1'b0);
    @(negedge clk) reset = 0;

    // Three writes.
    exp_q = '{TOK_S, tk(0, 8'h40), tk(0, 8'h06), tk(0, 8'hFF), tk(0, 8'h00), TOK_P};
    run("wr3", 7'h20, 2'd3, 2'd0, 8'h06, 8'hFF, 8'h00, 38 * 16, 0);
    cmp_tokens("wr3");
    chk("wr3_nack", bus_if.nack, 1'b0);

    // Write then repeated-START read; read count 3 acts as 2.
    exp_q = '{TOK_S, tk(0, 8'h40), tk(0, 8'h00), TOK_S, tk(0, 8'h41),
              tk(0, 8'h5A), tk(1, 8'hC3), TOK_P};
    run("wr1rd2", 7'h20, 2'd1, 2'd3, 8'h00, 8'h11, 8'h22, 48 * 16, 0);
    cmp_tokens("wr1rd2");
    chk("wr1rd2_rd0", bus_if.rd_data0, 8'h5A);
    chk("wr1rd2_rd1", bus_if.rd_data1, 8'hC3);
    chk("wr1rd2_nack", bus_if.nack, 1'b0);

    // Read-only single byte; rd_data1 keeps its old value.
    exp_q = '{TOK_S, tk(0, 8'h41), tk(1, 8'h5A), TOK_P};
    run("rd1", 7'h20, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 20 * 16, 0);
    cmp_tokens("rd1");
    chk("rd1_rd0", bus_if.rd_data0, 8'h5A);
    chk("rd1_rd1", bus_if.rd_data1, 8'hC3);

    // Probe of an absent slave, with a start pulse while busy.
    exp_q = '{TOK_S, tk(1, 8'h42), TOK_P};
    run("probe_miss", 7'h21, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 11 * 16, 1);
    cmp_tokens("probe_miss");
    chk("probe_miss_nack", bus_if.nack, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    chk("ignored_start_done", bus_if.done, 1'b1);
    chk("ignored_start_bus", got_q.size(), 0);

    // Probe of the present slave clears nack.
    exp_q = '{TOK_S, tk(0, 8'h40), TOK_P};
    run("probe_hit", 7'h20, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 11 * 16, 0);
    cmp_tokens("probe_hit");
    chk("probe_hit_nack", bus_if.nack, 1'b0);

    // Clock stretch of 100 cycles.
    stretch_arm = 1;
    exp_q = '{TOK_S, tk(0, 8'h40), tk(0, 8'hA5), tk(0, 8'h3C), TOK_P};
    run("stretch", 7'h20, 2'd2, 2'd0, 8'hA5, 8'h3C, 8'h00, 29 * 16 + 100, 0);
    stretch_arm = 0;
    cmp_tokens("stretch");
    chk("stretch_seen", hold_seen, 1'b1);
    chk("stretch_sda_stable", sda_moved, 1'b0);
    chk("stretch_released", hold_cnt, 0);

    // Reset during the second write byte.
    @(negedge clk);
    bus_if.addr = 7'h20; bus_if.num_wr_bytes = 2'd3; bus_if.num_rd_bytes = 2'd0;
    bus_if.wr_data0 = 8'h12; bus_if.wr_data1 = 8'h00; bus_if.wr_data2 = 8'h56;
    bus_if.start = 1;
    @(posedge clk); #1;
    bus_if.start = 0;
    k = 0;
    while (!(mph == 2 && wr_idx == 1 && mbit >= 3) && k < 5000) begin
      @(posedge clk); k++;
    end
    chk("rst_mid_reached", k < 5000, 1'b1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_scl", bus_if.scl_oe, 1'b0);
    chk("rst_mid_sda", bus_if.sda_oe, 1'b0);
    chk("rst_mid_done", bus_if.done, 1'b1);
    chk("rst_mid_rd0", bus_if.rd_data0, 8'h00);
    @(negedge clk);
    reset = 0; mon_clr = 1;
    repeat (2) @(negedge clk);
    mon_clr = 0;
    exp_q.delete(); got_q.delete();
    repeat (50) @(posedge clk);
    #1;
    chk("rst_mid_idle", bus_if.done, 1'b1);
    chk("rst_mid_quiet", got_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
